register_pipe: RTL
==================

REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits (N >= 1).
REQ-002 SHALL have parameter DEPTH, default 4, number of pipeline stages (DEPTH >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-low (clr=0 clears on the next rising clk edge).
REQ-005 SHALL have port en  input  1  global enable; 0 freezes all state.
REQ-006 SHALL have port flush  input  1  synchronous invalidate of all stages.
REQ-007 SHALL have port in_valid  input  1  upstream data valid.
REQ-008 SHALL have port in_data  input  N  upstream data.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  last stage holds valid data.
REQ-011 SHALL have port out_data  output  N  last-stage data.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL hold DEPTH stages, each an N-bit data register plus a valid bit; stage 0 is the input stage, stage DEPTH-1 drives out_data and out_valid directly from registers.
REQ-015 SHALL define input transfer as in_valid && in_ready and output transfer as out_valid && out_ready && en.
REQ-016 SHALL advance stage i (i < DEPTH-1) into stage i+1 when stage i is valid and stage i+1 is empty or advancing in the same cycle.
REQ-017 SHALL drive in_ready = en && !flush && (stage 0 empty || stage 0 advancing); in_ready is combinational from out_ready through the advance chain.
REQ-018 SHALL give latency of exactly DEPTH cycles: an item accepted at edge k shows out_valid=1 after edge k+DEPTH-1 when there is no backpressure, so it is visible during cycle k+DEPTH.
REQ-019 SHALL sustain one transfer per cycle when out_ready=1 continuously.
REQ-020 SHALL preserve order; no item lost or duplicated under any out_ready pattern.
REQ-021 SHALL, when full (count=DEPTH) with out_ready=1 and en=1, accept a new input in the same cycle (in_ready=1), so count stays DEPTH.
REQ-022 SHALL keep out_valid and out_data stable while out_valid=1 and no output transfer occurs.
REQ-023 SHALL update count each edge as count + input transfer - output transfer, in the range 0..DEPTH with no wrap.
REQ-024 SHALL, on flush=1 with en=1, clear all valid bits and set count=0 at that edge; data registers hold their values; no input is accepted and no output transfer counts that cycle.
REQ-025 SHALL, when en=0, hold all valid bits, data and count, with in_ready=0; out_valid keeps its registered value but no output transfer occurs; flush is ignored.
REQ-026 SHALL ignore in_data when in_valid=0; a stage's data register loads only on the edge its valid bit is set.

Reset
REQ-027 SHALL, at an edge with clr=0, clear all valid bits and data registers to 0, giving out_valid=0, out_data=0 and count=0, regardless of en, flush or the handshake inputs.
REQ-028 SHALL give clr priority over flush, which has priority over normal operation.
REQ-029 SHALL drive in_ready=1 in the first cycle after clr returns to 1, provided en=1 and flush=0.

Verification (DEPTH=4, N=8)
REQ-030 Reset: clr=0 for 2 edges mid-stream with count=3 -> out_valid=0, out_data=0x00, count=0; then clr=1, en=1 -> in_ready=1.
REQ-031 Streaming: push 0x01..0x08 on consecutive cycles with out_ready=1 -> 0x01 is visible 4 cycles after acceptance, then one item per cycle in order; count holds 4 once filled.
REQ-032 Backpressure: out_ready=0, push 0x10..0x15 -> only 0x10..0x13 accepted, in_ready=0 after the 4th, count=4; then out_ready=1 -> 0x10..0x15 emerge in order, no duplicates.
REQ-033 Full plus simultaneous push/pop: count=4, in_valid=1, out_ready=1 -> in_ready=1, count stays 4, out_data advances to the next item.
REQ-034 Flush: count=3, flush=1 with in_valid=1 -> in_ready=0; after the edge count=0 and out_valid=0; next push 0xAA emerges after 4 cycles.
REQ-035 Enable: en=0 for 3 cycles mid-stream with out_ready=1 -> count, out_data and out_valid frozen, in_ready=0; en=1 -> sequence resumes with no loss.

Source files
------------

// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage valid/ready register pipeline (clk, clr active-low sync reset, en, flush, in_valid/in_data/in_ready, out_valid/out_data/out_ready, count)
module register_pipe #(
  parameter int N = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [N-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v, go;
  logic [N-1:0] d [DEPTH];
  logic run, in_x, out_x;
  always_comb begin
    run = en && !flush;
    go = '0;
    go[DEPTH-1] = run && v[DEPTH-1] && out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) go[i] = run && v[i] && (!v[i+1] || go[i+1]);
    in_ready = run && (!v[0] || go[0]);
    in_x = in_valid && in_ready;
    out_x = go[DEPTH-1];
  end
  assign out_valid = v[DEPTH-1];
  assign out_data = d[DEPTH-1];
  always_ff @(posedge clk) begin
    if (!clr) begin
      v <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (en) begin
      if (flush) begin
        v <= '0;
        count <= '0;
      end else begin
        count <= count + CW'(in_x) - CW'(out_x);
        if (in_x) begin
          v[0] <= 1'b1;
          d[0] <= in_data;
        end else if (go[0]) v[0] <= 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
          if (go[i-1]) begin
            v[i] <= 1'b1;
            d[i] <= d[i-1];
          end else if (go[i]) v[i] <= 1'b0;
        end
      end
    end
  end
endmodule
